// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states and decode helpers.
package load_store_unit_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_REQ2  = 3'd4,
        ST_WAIT2 = 3'd5
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    // Stores have no unsigned variants; 64-bit codes only exist on a 64-bit datapath.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic store, input int xlen);
        logic ok;
        ok = 1'b1;
        if (f3 == 3'b111) ok = 1'b0;
        if (xlen == 32 && (f3 == LSU_D || f3 == LSU_WU)) ok = 1'b0;
        if (store && f3[2]) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response handshake and data-bus interfaces of the load/store unit.
interface lsu_exec_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_error;

    modport master (output req_valid, req_store, req_funct3, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_error);
    modport slave  (input  req_valid, req_store, req_funct3, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, rsp_error);
endinterface

interface lsu_bus_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
    logic              bus_req;
    logic              bus_gnt;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic [XLEN/8-1:0] bus_be;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rdata;
    logic              bus_err;

    modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                    input  bus_gnt, bus_rvalid, bus_rdata, bus_err);
    modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                    output bus_gnt, bus_rvalid, bus_rdata, bus_err);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment: store shift / byte-enable generation and load extract / extend.
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NB     = XLEN / 8,
    parameter int LANE_W = $clog2(NB)
) (
    input  logic [2:0]        funct3,
    input  logic [LANE_W-1:0] lane,
    input  logic [XLEN-1:0]   st_data,
    output logic [XLEN-1:0]   st_lo,
    output logic [XLEN-1:0]   st_hi,
    output logic [NB-1:0]     be_lo,
    output logic [NB-1:0]     be_hi,
    input  logic [XLEN-1:0]   ld_lo,
    input  logic [XLEN-1:0]   ld_hi,
    output logic [XLEN-1:0]   ld_data
);

    logic [XLEN-1:0]   size_mask;
    logic [NB-1:0]     be_mask;
    logic [2*XLEN-1:0] st_wide;
    logic [2*NB-1:0]   be_wide;
    logic [XLEN-1:0]   ld_shift;

    always_comb begin
        case (funct3[1:0])
            2'b00:   begin size_mask = XLEN'(8'hFF);         be_mask = NB'(4'h1); end
            2'b01:   begin size_mask = XLEN'(16'hFFFF);      be_mask = NB'(4'h3); end
            2'b10:   begin size_mask = XLEN'(32'hFFFF_FFFF); be_mask = NB'(4'hF); end
            default: begin size_mask = '1;                   be_mask = '1;        end
        endcase
    end

    // Two-word window: the upper half is the spill into the next bus word.
    assign st_wide  = {{XLEN{1'b0}}, st_data & size_mask} << {lane, 3'b000};
    assign be_wide  = {{NB{1'b0}}, be_mask} << lane;
    assign st_lo    = st_wide[XLEN-1:0];
    assign st_hi    = st_wide[2*XLEN-1:XLEN];
    assign be_lo    = be_wide[NB-1:0];
    assign be_hi    = be_wide[2*NB-1:NB];
    assign ld_shift = XLEN'({ld_hi, ld_lo} >> {lane, 3'b000});

    always_comb begin
        case (funct3)
            LSU_B:   ld_data = XLEN'($signed(ld_shift[7:0]));
            LSU_H:   ld_data = XLEN'($signed(ld_shift[15:0]));
            LSU_W:   ld_data = XLEN'($signed(ld_shift[31:0]));
            LSU_BU:  ld_data = XLEN'(ld_shift[7:0]);
            LSU_HU:  ld_data = XLEN'(ld_shift[15:0]);
            LSU_WU:  ld_data = XLEN'(ld_shift[31:0]);
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one execute request -> one or two bus beats -> one response pulse.
// Define LSU_MISALIGNED_SPLIT_EN to service misaligned accesses (split across words) instead of faulting.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int BUS_TIMEOUT = 0
) (
    input logic       clk,
    input logic       rst_n,
    lsu_exec_if.slave exe,
    lsu_bus_if.master bus
);

    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int TO_W   = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_e state_q, state_d;

    logic              op_store;
    logic [2:0]        op_funct3;
    logic [LANE_W-1:0] op_lane;
    logic              op_split;
    logic [ADDR_W-1:0] op_addr2;
    logic [XLEN-1:0]   wdata_hi_q;
    logic [NB-1:0]     be_hi_q;
    logic [XLEN-1:0]   rdata_lo_q;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout_hit;

    logic              accept, req_bad, req_misal, req_cross;
    logic [3:0]        req_size;
    logic [LANE_W-1:0] req_lane;
    logic [ADDR_W-1:0] req_base;

    logic [2:0]        al_funct3;
    logic [LANE_W-1:0] al_lane;
    logic [XLEN-1:0]   al_ld_lo, al_ld_hi, al_ld, al_st_lo, al_st_hi;
    logic [NB-1:0]     al_be_lo, al_be_hi;

    logic              req_ready_d, rsp_valid_d, rsp_error_d, bus_req_d, bus_we_d;
    logic [XLEN-1:0]   rsp_rdata_d, bus_wdata_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [NB-1:0]     bus_be_d;

    assign accept    = exe.req_valid & exe.req_ready;
    assign req_size  = size_bytes(exe.req_funct3);
    assign req_lane  = exe.req_addr[LANE_W-1:0];
    assign req_base  = {exe.req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
    assign req_misal = (exe.req_addr[3:0] & (req_size - 4'd1)) != 4'd0;
    assign req_cross = (int'(req_lane) + int'(req_size)) > NB;
    assign req_bad   = !funct3_legal(exe.req_funct3, exe.req_store, XLEN) || (req_misal && !SPLIT_EN);

    assign timeout_hit = (BUS_TIMEOUT != 0) && (to_cnt == TO_W'(BUS_TIMEOUT - 1));

    // The aligner serves the incoming request in IDLE and the latched one afterwards.
    assign al_funct3 = (state_q == ST_IDLE) ? exe.req_funct3 : op_funct3;
    assign al_lane   = (state_q == ST_IDLE) ? req_lane : op_lane;
    assign al_ld_lo  = (state_q == ST_WAIT2) ? rdata_lo_q : bus.bus_rdata;
    assign al_ld_hi  = (state_q == ST_WAIT2) ? bus.bus_rdata : '0;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .funct3  (al_funct3),
        .lane    (al_lane),
        .st_data (exe.req_wdata),
        .st_lo   (al_st_lo),
        .st_hi   (al_st_hi),
        .be_lo   (al_be_lo),
        .be_hi   (al_be_hi),
        .ld_lo   (al_ld_lo),
        .ld_hi   (al_ld_hi),
        .ld_data (al_ld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = req_bad ? ST_RESP : ST_REQ;
            ST_REQ:   if (bus.bus_gnt) state_d = ST_WAIT;
                      else if (timeout_hit) state_d = ST_RESP;
            ST_WAIT:  if (bus.bus_rvalid) state_d = (op_split && !bus.bus_err) ? ST_REQ2 : ST_RESP;
                      else if (timeout_hit) state_d = ST_RESP;
            ST_REQ2:  if (bus.bus_gnt) state_d = ST_WAIT2;
                      else if (timeout_hit) state_d = ST_RESP;
            ST_WAIT2: if (bus.bus_rvalid || timeout_hit) state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        bus_req_d   = (state_d == ST_REQ) || (state_d == ST_REQ2);
        rsp_error_d = exe.rsp_error;
        rsp_rdata_d = exe.rsp_rdata;
        bus_we_d    = bus.bus_we;
        bus_addr_d  = bus.bus_addr;
        bus_wdata_d = bus.bus_wdata;
        bus_be_d    = bus.bus_be;
        case (state_q)
            ST_IDLE: if (accept) begin
                rsp_error_d = req_bad;
                rsp_rdata_d = '0;
                bus_we_d    = exe.req_store;
                bus_addr_d  = req_base;
                bus_wdata_d = al_st_lo;
                bus_be_d    = al_be_lo;
            end
            ST_REQ, ST_REQ2: if (!bus.bus_gnt && timeout_hit) rsp_error_d = 1'b1;
            ST_WAIT: begin
                if (bus.bus_rvalid) begin
                    if (bus.bus_err) rsp_error_d = 1'b1;
                    else if (op_split) begin
                        bus_addr_d  = op_addr2;
                        bus_wdata_d = wdata_hi_q;
                        bus_be_d    = be_hi_q;
                    end else if (!op_store) rsp_rdata_d = al_ld;
                end else if (timeout_hit) rsp_error_d = 1'b1;
            end
            ST_WAIT2: begin
                if (bus.bus_rvalid) begin
                    if (bus.bus_err) rsp_error_d = 1'b1;
                    else if (!op_store) rsp_rdata_d = al_ld;
                end else if (timeout_hit) rsp_error_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe.req_ready <= 1'b1;
            exe.rsp_valid <= 1'b0;
            exe.rsp_error <= 1'b0;
            exe.rsp_rdata <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
        end else begin
            exe.req_ready <= req_ready_d;
            exe.rsp_valid <= rsp_valid_d;
            exe.rsp_error <= rsp_error_d;
            exe.rsp_rdata <= rsp_rdata_d;
            bus.bus_req   <= bus_req_d;
            bus.bus_we    <= bus_we_d;
            bus.bus_addr  <= bus_addr_d;
            bus.bus_wdata <= bus_wdata_d;
            bus.bus_be    <= bus_be_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_store   <= 1'b0;
            op_funct3  <= '0;
            op_lane    <= '0;
            op_split   <= 1'b0;
            op_addr2   <= '0;
            wdata_hi_q <= '0;
            be_hi_q    <= '0;
            rdata_lo_q <= '0;
        end else begin
            if (accept) begin
                op_store   <= exe.req_store;
                op_funct3  <= exe.req_funct3;
                op_lane    <= req_lane;
                op_split   <= req_cross && SPLIT_EN;
                op_addr2   <= req_base + ADDR_W'(NB);
                wdata_hi_q <= al_st_hi;
                be_hi_q    <= al_be_hi;
            end
            if (state_q == ST_WAIT && bus.bus_rvalid) rdata_lo_q <= bus.bus_rdata;
        end
    end

    // Restarts on every state change, so REQ and WAIT each get the full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  to_cnt <= '0;
        else if (state_d != state_q) to_cnt <= '0;
        else                         to_cnt <= to_cnt + 1'b1;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32, BUS_TIMEOUT=8) with hand-computed expectations.
module tb_load_store_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lsu_exec_if #(.XLEN(32), .ADDR_W(32)) exe();
    lsu_bus_if  #(.XLEN(32), .ADDR_W(32)) bus();

    load_store_unit #(.XLEN(32), .ADDR_W(32), .BUS_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .exe   (exe),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        exe.req_valid  = 1'b1;
        exe.req_store  = st;
        exe.req_funct3 = f3;
        exe.req_addr   = a;
        exe.req_wdata  = wd;
        tick();
        exe.req_valid  = 1'b0;
    endtask

    task automatic grant();
        bus.bus_gnt = 1'b1;
        tick();
        bus.bus_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd, input logic err);
        bus.bus_rvalid = 1'b1;
        bus.bus_rdata  = rd;
        bus.bus_err    = err;
        tick();
        bus.bus_rvalid = 1'b0;
        bus.bus_err    = 1'b0;
    endtask

    initial begin
        exe.req_valid  = 1'b0;
        exe.req_store  = 1'b0;
        exe.req_funct3 = 3'b000;
        exe.req_addr   = '0;
        exe.req_wdata  = '0;
        bus.bus_gnt    = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata  = '0;
        bus.bus_err    = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        check("rst req_ready", exe.req_ready, 1);
        check("rst rsp_valid", exe.rsp_valid, 0);
        check("rst rsp_error", exe.rsp_error, 0);
        check("rst rsp_rdata", exe.rsp_rdata, 0);
        check("rst bus_req",   bus.bus_req, 0);
        check("rst bus_we",    bus.bus_we, 0);
        check("rst bus_addr",  bus.bus_addr, 0);
        check("rst bus_wdata", bus.bus_wdata, 0);
        check("rst bus_be",    bus.bus_be, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // SW 0xDEADBEEF @0x100
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        check("sw bus_req",   bus.bus_req, 1);
        check("sw req_ready", exe.req_ready, 0);
        check("sw bus_addr",  bus.bus_addr, 32'h100);
        check("sw bus_be",    bus.bus_be, 4'hF);
        check("sw bus_wdata", bus.bus_wdata, 32'hDEADBEEF);
        check("sw bus_we",    bus.bus_we, 1);
        grant();
        check("sw req after gnt", bus.bus_req, 0);
        check("sw no early rsp",  exe.rsp_valid, 0);
        respond(32'h0, 1'b0);
        check("sw rsp_valid", exe.rsp_valid, 1);
        check("sw rsp_error", exe.rsp_error, 0);
        check("sw rsp_rdata", exe.rsp_rdata, 0);
        tick();
        check("sw rsp pulse",  exe.rsp_valid, 0);
        check("sw ready back", exe.req_ready, 1);

        // LB @0x103, sign-extended top byte
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        check("lb bus_addr", bus.bus_addr, 32'h100);
        check("lb bus_be",   bus.bus_be, 4'h8);
        check("lb bus_we",   bus.bus_we, 0);
        grant();
        respond(32'h80FF0000, 1'b0);
        check("lb rsp_valid", exe.rsp_valid, 1);
        check("lb rsp_rdata", exe.rsp_rdata, 32'hFFFFFF80);
        tick();

        // LBU same address and data
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        grant();
        respond(32'h80FF0000, 1'b0);
        check("lbu rsp_rdata", exe.rsp_rdata, 32'h00000080);
        check("lbu rsp_error", exe.rsp_error, 0);
        tick();

        // SH 0x1234 @0x102 with three stalled grant cycles
        issue(1'b1, 3'b001, 32'h102, 32'hCAFE1234);
        for (int i = 0; i < 3; i++) begin
            check("sh held bus_req", bus.bus_req, 1);
            check("sh held bus_addr", bus.bus_addr, 32'h100);
            check("sh held bus_be", bus.bus_be, 4'hC);
            check("sh held bus_wdata", bus.bus_wdata, 32'h12340000);
            tick();
        end
        check("sh bus_req before gnt", bus.bus_req, 1);
        grant();
        respond(32'h0, 1'b0);
        check("sh rsp_valid", exe.rsp_valid, 1);
        check("sh rsp_error", exe.rsp_error, 0);
        tick();

        // LH @0x102 sign-extends upper half
        issue(1'b0, 3'b001, 32'h102, 32'h0);
        grant();
        respond(32'h80015555, 1'b0);
        check("lh rsp_rdata", exe.rsp_rdata, 32'hFFFF8001);
        tick();

        // LHU @0x100 zero-extends lower half
        issue(1'b0, 3'b101, 32'h100, 32'h0);
        grant();
        respond(32'h1234ABCD, 1'b0);
        check("lhu rsp_rdata", exe.rsp_rdata, 32'h0000ABCD);
        tick();

        // LW @0x102 crosses a word boundary
        issue(1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        check("lw split beat1 addr", bus.bus_addr, 32'h100);
        check("lw split beat1 be",   bus.bus_be, 4'hC);
        grant();
        respond(32'hAABBCCDD, 1'b0);
        check("lw split beat2 req",  bus.bus_req, 1);
        check("lw split beat2 addr", bus.bus_addr, 32'h104);
        check("lw split beat2 be",   bus.bus_be, 4'h3);
        grant();
        respond(32'h11223344, 1'b0);
        check("lw split rsp_valid", exe.rsp_valid, 1);
        check("lw split rsp_rdata", exe.rsp_rdata, 32'h3344AABB);
        check("lw split rsp_error", exe.rsp_error, 0);
`else
        check("lw misal rsp_valid", exe.rsp_valid, 1);
        check("lw misal rsp_error", exe.rsp_error, 1);
        check("lw misal no bus_req", bus.bus_req, 0);
`endif
        tick();
        check("lw misal ready back", exe.req_ready, 1);

        // Illegal funct3: LD on 32-bit, store with unsigned code
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        check("ld32 rsp_valid", exe.rsp_valid, 1);
        check("ld32 rsp_error", exe.rsp_error, 1);
        check("ld32 no bus_req", bus.bus_req, 0);
        check("ld32 rsp_rdata", exe.rsp_rdata, 0);
        tick();
        issue(1'b1, 3'b100, 32'h100, 32'h55);
        check("sbu rsp_error", exe.rsp_error, 1);
        check("sbu no bus_req", bus.bus_req, 0);
        tick();

        // Bus error on a load
        issue(1'b0, 3'b010, 32'h200, 32'h0);
        grant();
        respond(32'h12345678, 1'b1);
        check("berr rsp_valid", exe.rsp_valid, 1);
        check("berr rsp_error", exe.rsp_error, 1);
        check("berr rsp_rdata", exe.rsp_rdata, 0);
        tick();

        // Grant never arrives: 8 REQ cycles then error response
        issue(1'b0, 3'b010, 32'h300, 32'h0);
        check("to req cycle 1", bus.bus_req, 1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check($sformatf("to req cycle %0d", i), bus.bus_req, 1);
        end
        tick();
        check("to bus_req dropped", bus.bus_req, 0);
        check("to rsp_valid", exe.rsp_valid, 1);
        check("to rsp_error", exe.rsp_error, 1);
        tick();
        check("to ready back", exe.req_ready, 1);

        // Reset while requesting: bus_req falls without a clock edge
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("rst in req bus_req", bus.bus_req, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Reset while waiting for rvalid, then a stray rvalid
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        grant();
        check("wait ready low", exe.req_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst in wait bus_req", bus.bus_req, 0);
        check("rst in wait ready",   exe.req_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        respond(32'hFFFFFFFF, 1'b0);
        check("stray rvalid no rsp", exe.rsp_valid, 0);
        tick();
        check("stray rvalid no rsp later", exe.rsp_valid, 0);
        check("post reset ready", exe.req_ready, 1);

        // Recovery: LBU @0x101
        issue(1'b0, 3'b100, 32'h101, 32'h0);
        check("rec bus_be", bus.bus_be, 4'h2);
        grant();
        respond(32'h0000A500, 1'b0);
        check("rec rsp_rdata", exe.rsp_rdata, 32'h000000A5);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
